// File: rtl/vout_stage_guarded.sv
// Video output stage: fixed-latency delay of sync/DE/pixel data towards the transmitter,
// gated off until HSYNC has locked and a frame start (VSYNC edge) has been observed.
module vout_stage_guarded #(
  parameter int color_width = 8,
  parameter int channels    = 3,
  parameter int pipe_stages = 1,
  parameter int wd_limit    = 4095,
  parameter int lock_lines  = 8
) (
  input  logic                             VCLK_Tx,
  input  logic                             VRST_Tx,
  input  logic                             VSYNC_i,
  input  logic                             HSYNC_i,
  input  logic                             DE_i,
  input  logic [channels*color_width-1:0]  VD_i,
  input  logic                             cfg_vsync_pol,
  input  logic                             cfg_hsync_pol,
  input  logic                             cfg_blank_en,
  output logic                             VSYNC_o,
  output logic                             HSYNC_o,
  output logic                             DE_o,
  output logic [channels*color_width-1:0]  VD_o,
  output logic                             sync_ok_o,
  output logic [7:0]                       frame_cnt_o
);

  // state   | meaning
  // IDLE    | no horizontal lock; outputs blanked
  // LOCKING | counting consecutive HSYNC rising edges
  // WAIT_VS | line-locked, waiting for a frame start
  // RUN     | video passed through to the transmitter

  localparam int DW = channels * color_width;
  localparam int PW = DW + 3;
  localparam logic [7:0]  LOCK_LINES = 8'(lock_lines);
  localparam logic [15:0] WD_LIMIT   = 16'(wd_limit);

  typedef enum logic [1:0] {IDLE, LOCKING, WAIT_VS, RUN} state_t;

  state_t      state;
  logic [7:0]  lock_cnt;
  logic [15:0] wd_cnt;
  logic        hs_q, vs_q;
  logic        hs_rise, vs_rise, timeout;

  logic [PW-1:0] pipe_in, pipe_tap;
  logic          tap_vs, tap_hs, tap_de;
  logic [DW-1:0] tap_vd;

  assign pipe_in = {VSYNC_i, HSYNC_i, DE_i, VD_i};

  // The output register is the last stage, so only pipe_stages-1 stages live here.
  generate
    if (pipe_stages > 1) begin : g_dly
      logic [PW-1:0] dly_q [pipe_stages-1];
      always_ff @(posedge VCLK_Tx or posedge VRST_Tx) begin
        if (VRST_Tx) begin
          for (int i = 0; i < pipe_stages-1; i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= pipe_in;
          for (int i = 1; i < pipe_stages-1; i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign pipe_tap = dly_q[pipe_stages-2];
    end else begin : g_nodly
      assign pipe_tap = pipe_in;
    end
  endgenerate

  assign tap_vs = pipe_tap[PW-1];
  assign tap_hs = pipe_tap[PW-2];
  assign tap_de = pipe_tap[PW-3];
  assign tap_vd = pipe_tap[DW-1:0];

  assign hs_rise = HSYNC_i & ~hs_q;
  assign vs_rise = VSYNC_i & ~vs_q;
  assign timeout = (wd_cnt == WD_LIMIT);

  always_ff @(posedge VCLK_Tx or posedge VRST_Tx) begin
    if (VRST_Tx) begin
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      wd_cnt <= '0;
    end else begin
      hs_q <= HSYNC_i;
      vs_q <= VSYNC_i;
      if (hs_rise)
        wd_cnt <= '0;
      else if (!timeout)
        wd_cnt <= wd_cnt + 16'd1;
    end
  end

  always_ff @(posedge VCLK_Tx or posedge VRST_Tx) begin
    if (VRST_Tx) begin
      state       <= IDLE;
      lock_cnt    <= '0;
      sync_ok_o   <= 1'b0;
      frame_cnt_o <= '0;
    end else if (timeout && state != IDLE) begin
      // sync loss wins over any edge arriving in the same cycle
      state     <= IDLE;
      lock_cnt  <= '0;
      sync_ok_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (hs_rise) begin
            lock_cnt <= 8'd1;
            state    <= (LOCK_LINES == 8'd1) ? WAIT_VS : LOCKING;
          end
        end
        LOCKING: begin
          if (hs_rise) begin
            lock_cnt <= lock_cnt + 8'd1;
            if (lock_cnt + 8'd1 == LOCK_LINES)
              state <= WAIT_VS;
          end
        end
        WAIT_VS: begin
          if (vs_rise) begin
            state     <= RUN;
            sync_ok_o <= 1'b1;
          end
        end
        RUN: begin
          if (vs_rise)
            frame_cnt_o <= frame_cnt_o + 8'd1;
        end
        default: begin
          state     <= IDLE;
          lock_cnt  <= '0;
          sync_ok_o <= 1'b0;
        end
      endcase
    end
  end

  // Gating uses the state register as it stands at the loading edge.
  always_ff @(posedge VCLK_Tx or posedge VRST_Tx) begin
    if (VRST_Tx) begin
      VSYNC_o <= 1'b0;
      HSYNC_o <= 1'b0;
      DE_o    <= 1'b0;
      VD_o    <= '0;
    end else if (state == RUN) begin
      VSYNC_o <= tap_vs ~^ cfg_vsync_pol;
      HSYNC_o <= tap_hs ~^ cfg_hsync_pol;
      DE_o    <= tap_de;
      VD_o    <= (cfg_blank_en && !tap_de) ? '0 : tap_vd;
    end else begin
      VSYNC_o <= ~cfg_vsync_pol;
      HSYNC_o <= ~cfg_hsync_pol;
      DE_o    <= 1'b0;
      VD_o    <= '0;
    end
  end

endmodule

// File: tb/tb_vout_stage_guarded.sv
// Bench for vout_stage_guarded: lock/run/timeout sequencing and gated output path
// against a behavioural model of the line/frame rules.
module tb_vout_stage_guarded;
  localparam int CW = 8;
  localparam int CH = 3;
  localparam int PS = 2;
  localparam int WD = 4095;
  localparam int LL = 8;
  localparam int DW = CW * CH;

  logic          VCLK_Tx = 1'b0;
  logic          VRST_Tx = 1'b1;
  logic          VSYNC_i = 1'b0, HSYNC_i = 1'b0, DE_i = 1'b0;
  logic [DW-1:0] VD_i = '0;
  logic          cfg_vsync_pol = 1'b1, cfg_hsync_pol = 1'b1, cfg_blank_en = 1'b0;
  logic          VSYNC_o, HSYNC_o, DE_o, sync_ok_o;
  logic [DW-1:0] VD_o;
  logic [7:0]    frame_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  vout_stage_guarded #(
    .color_width(CW), .channels(CH), .pipe_stages(PS), .wd_limit(WD), .lock_lines(LL)
  ) dut (
    .VCLK_Tx(VCLK_Tx), .VRST_Tx(VRST_Tx),
    .VSYNC_i(VSYNC_i), .HSYNC_i(HSYNC_i), .DE_i(DE_i), .VD_i(VD_i),
    .cfg_vsync_pol(cfg_vsync_pol), .cfg_hsync_pol(cfg_hsync_pol), .cfg_blank_en(cfg_blank_en),
    .VSYNC_o(VSYNC_o), .HSYNC_o(HSYNC_o), .DE_o(DE_o), .VD_o(VD_o),
    .sync_ok_o(sync_ok_o), .frame_cnt_o(frame_cnt_o)
  );

  always #5 VCLK_Tx = ~VCLK_Tx;

  // ---------------- behavioural reference ----------------
  typedef struct packed {logic vs; logic hs; logic de; logic [DW-1:0] vd;} smp_t;
  smp_t hist[$];
  bit   m_hs_prev, m_vs_prev, m_running;
  int   m_edges, m_idle, m_frames;
  logic e_vs, e_hs, e_de;
  logic [DW-1:0] e_vd;

  function automatic logic [DW-1:0] rnd_vd();
    logic [31:0] r;
    r = $urandom;
    return r[DW-1:0];
  endfunction

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < PS; i++) hist.push_front('0);
    m_hs_prev = 0; m_vs_prev = 0; m_running = 0;
    m_edges = 0; m_idle = 0; m_frames = 0;
    e_vs = 0; e_hs = 0; e_de = 0; e_vd = '0;
  endtask

  task automatic model_edge();
    smp_t cur, tap;
    bit hr, vr, lost;
    cur = {VSYNC_i, HSYNC_i, DE_i, VD_i};
    hist.push_front(cur);
    tap = hist[PS-1];
    void'(hist.pop_back());
    if (m_running) begin
      e_de = tap.de;
      e_vd = (cfg_blank_en && !tap.de) ? '0 : tap.vd;
      e_hs = cfg_hsync_pol ? tap.hs : !tap.hs;
      e_vs = cfg_vsync_pol ? tap.vs : !tap.vs;
    end else begin
      e_de = 0; e_vd = '0;
      e_hs = !cfg_hsync_pol;
      e_vs = !cfg_vsync_pol;
    end
    hr   = HSYNC_i && !m_hs_prev;
    vr   = VSYNC_i && !m_vs_prev;
    lost = (m_idle >= WD);
    if (lost && m_edges > 0) begin
      m_edges = 0; m_running = 0;
    end else if (m_edges < LL) begin
      if (hr) m_edges++;
    end else if (!m_running) begin
      if (vr) m_running = 1;
    end else if (vr) begin
      m_frames++;
    end
    m_idle = hr ? 0 : ((m_idle < WD) ? m_idle + 1 : WD);
    m_hs_prev = HSYNC_i;
    m_vs_prev = VSYNC_i;
  endtask

  task automatic tick();
    @(posedge VCLK_Tx);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic vs, input logic hs, input logic de, input logic [DW-1:0] vd);
    VSYNC_i = vs; HSYNC_i = hs; DE_i = de; VD_i = vd;
    tick();
  endtask

  task automatic lock_lines_only();
    for (int l = 0; l < LL; l++)
      for (int c = 0; c < 100; c++) drive(1'b0, c < 10, (c >= 20 && c < 90), rnd_vd());
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    VRST_Tx = 1'b1;
    model_reset();
    repeat (2) @(posedge VCLK_Tx);
    #1;
    n_checks++; if (VSYNC_o !== 1'b0) begin n_fail++; $display("FAIL reset_vsync: got %b want 0", VSYNC_o); end
    n_checks++; if (HSYNC_o !== 1'b0) begin n_fail++; $display("FAIL reset_hsync: got %b want 0", HSYNC_o); end
    n_checks++; if (DE_o !== 1'b0) begin n_fail++; $display("FAIL reset_de: got %b want 0", DE_o); end
    n_checks++; if (VD_o !== '0) begin n_fail++; $display("FAIL reset_vd: got %h want 0", VD_o); end
    n_checks++; if (sync_ok_o !== 1'b0) begin n_fail++; $display("FAIL reset_sync_ok: got %b want 0", sync_ok_o); end
    n_checks++; if (frame_cnt_o !== 8'd0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt_o); end
    VRST_Tx = 1'b0;
  endtask

  task automatic test_lock();
    for (int l = 0; l < LL; l++)
      for (int c = 0; c < 100; c++) begin
        drive(1'b0, c < 10, (c >= 20 && c < 90), rnd_vd());
        n_checks++;
        if ({VSYNC_o, HSYNC_o, DE_o, VD_o, sync_ok_o, frame_cnt_o} !== {e_vs, e_hs, e_de, e_vd, m_running, 8'(m_frames)}) begin
          n_fail++;
          $display("FAIL lock_cycle l%0d c%0d: got %b%b%b %h ok=%b fc=%0d want %b%b%b %h ok=%b fc=%0d", l, c,
                   VSYNC_o, HSYNC_o, DE_o, VD_o, sync_ok_o, frame_cnt_o, e_vs, e_hs, e_de, e_vd, m_running, 8'(m_frames));
        end
      end
    n_checks++; if (sync_ok_o !== 1'b0) begin n_fail++; $display("FAIL lock_before_vs: got %b want 0", sync_ok_o); end
    drive(1'b1, 1'b1, 1'b0, '0);
    n_checks++; if (sync_ok_o !== 1'b1) begin n_fail++; $display("FAIL lock_after_vs: got %b want 1", sync_ok_o); end
    n_checks++; if (frame_cnt_o !== 8'd0) begin n_fail++; $display("FAIL lock_entry_not_counted: got %0d want 0", frame_cnt_o); end
    drive(1'b1, 1'b1, 1'b1, 24'hA5A5A5);
    for (int k = 1; k <= PS; k++) begin
      if (k > 1) drive(1'b1, 1'b0, 1'b0, '0);
      n_checks++;
      if (DE_o !== (k == PS)) begin n_fail++; $display("FAIL latency_de k=%0d: got %b want %b", k, DE_o, (k == PS)); end
    end
    n_checks++; if (VD_o !== 24'hA5A5A5) begin n_fail++; $display("FAIL latency_vd: got %h want a5a5a5", VD_o); end
    for (int c = 0; c < 90; c++) drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_random();
    for (int l = 0; l < 20; l++) begin
      int hw;
      cfg_hsync_pol = 1'($urandom_range(0, 1));
      cfg_vsync_pol = 1'($urandom_range(0, 1));
      cfg_blank_en  = 1'($urandom_range(0, 1));
      hw = $urandom_range(1, 20);
      for (int c = 0; c < 100; c++) begin
        drive((l % 4 == 0) && c < 3, c < hw, 1'($urandom_range(0, 1)), rnd_vd());
        n_checks++;
        if ({VSYNC_o, HSYNC_o, DE_o, VD_o, sync_ok_o, frame_cnt_o} !== {e_vs, e_hs, e_de, e_vd, m_running, 8'(m_frames)}) begin
          n_fail++;
          $display("FAIL random_cycle l%0d c%0d: got %b%b%b %h ok=%b fc=%0d want %b%b%b %h ok=%b fc=%0d", l, c,
                   VSYNC_o, HSYNC_o, DE_o, VD_o, sync_ok_o, frame_cnt_o, e_vs, e_hs, e_de, e_vd, m_running, 8'(m_frames));
        end
      end
    end
    n_checks++; if (frame_cnt_o !== 8'd5) begin n_fail++; $display("FAIL random_frames: got %0d want 5", frame_cnt_o); end
  endtask

  task automatic test_polarity();
    cfg_hsync_pol = 1'b0; cfg_vsync_pol = 1'b1; cfg_blank_en = 1'b0;
    drive(1'b0, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b1, 1'b0, '0);
    n_checks++; if (HSYNC_o !== 1'b0) begin n_fail++; $display("FAIL pol_hsync_active: got %b want 0", HSYNC_o); end
    n_checks++; if (VSYNC_o !== 1'b0) begin n_fail++; $display("FAIL pol_vsync_idle: got %b want 0", VSYNC_o); end
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    n_checks++; if (HSYNC_o !== 1'b1) begin n_fail++; $display("FAIL pol_hsync_inactive: got %b want 1", HSYNC_o); end
    n_checks++; if (VSYNC_o !== 1'b1) begin n_fail++; $display("FAIL pol_vsync_active: got %b want 1", VSYNC_o); end
    drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_blank();
    cfg_blank_en = 1'b1;
    repeat (PS) drive(1'b0, 1'b0, 1'b0, 24'hFFFFFF);
    n_checks++; if (VD_o !== 24'h000000) begin n_fail++; $display("FAIL blank_on: got %h want 000000", VD_o); end
    cfg_blank_en = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 24'hFFFFFF);
    n_checks++; if (VD_o !== 24'hFFFFFF) begin n_fail++; $display("FAIL blank_off: got %h want ffffff", VD_o); end
  endtask

  task automatic test_timeout();
    logic [7:0] f0;
    f0 = 8'(m_frames);
    drive(1'b0, 1'b1, 1'b1, rnd_vd());
    repeat (WD) drive(1'b0, 1'b0, 1'b1, rnd_vd());
    n_checks++; if (sync_ok_o !== 1'b1) begin n_fail++; $display("FAIL timeout_edge_minus1: got %b want 1", sync_ok_o); end
    drive(1'b0, 1'b0, 1'b1, rnd_vd());
    n_checks++; if (sync_ok_o !== 1'b0) begin n_fail++; $display("FAIL timeout_sync_ok: got %b want 0", sync_ok_o); end
    drive(1'b0, 1'b0, 1'b1, 24'h123456);
    n_checks++; if (DE_o !== 1'b0) begin n_fail++; $display("FAIL timeout_de: got %b want 0", DE_o); end
    n_checks++; if (VD_o !== '0) begin n_fail++; $display("FAIL timeout_vd: got %h want 0", VD_o); end
    n_checks++; if (HSYNC_o !== 1'b1) begin n_fail++; $display("FAIL idle_hsync_pol0: got %b want 1", HSYNC_o); end
    n_checks++; if (VSYNC_o !== 1'b0) begin n_fail++; $display("FAIL idle_vsync_pol1: got %b want 0", VSYNC_o); end
    n_checks++; if (frame_cnt_o !== f0) begin n_fail++; $display("FAIL timeout_frame_hold: got %0d want %0d", frame_cnt_o, f0); end
  endtask

  task automatic test_timeout_vs();
    cfg_hsync_pol = 1'b1; cfg_vsync_pol = 1'b1;
    lock_lines_only();
    drive(1'b0, 1'b1, 1'b0, '0);
    repeat (WD) drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    n_checks++; if (sync_ok_o !== 1'b0) begin n_fail++; $display("FAIL to_vs_collide: got %b want 0", sync_ok_o); end
    n_checks++; if (sync_ok_o !== m_running) begin n_fail++; $display("FAIL to_vs_model: got %b want %b", sync_ok_o, m_running); end
    drive(1'b1, 1'b0, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 1'b0, '0);
    n_checks++; if (sync_ok_o !== 1'b0) begin n_fail++; $display("FAIL to_vs_stays_idle: got %b want 0", sync_ok_o); end
    drive(1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_frame_wrap();
    VRST_Tx = 1'b1;
    model_reset();
    @(posedge VCLK_Tx); #1;
    VRST_Tx = 1'b0;
    lock_lines_only();
    drive(1'b1, 1'b1, 1'b0, '0);
    drive(1'b0, 1'b0, 1'b0, '0);
    for (int f = 1; f <= 256; f++) begin
      drive(1'b1, 1'b1, 1'b1, rnd_vd());
      drive(1'b0, 1'b0, 1'b1, rnd_vd());
      drive(1'b0, 1'b0, 1'b0, rnd_vd());
      n_checks++;
      if ({VSYNC_o, HSYNC_o, DE_o, VD_o, sync_ok_o, frame_cnt_o} !== {e_vs, e_hs, e_de, e_vd, m_running, 8'(m_frames)}) begin
        n_fail++;
        $display("FAIL wrap_frame %0d: got %b%b%b %h ok=%b fc=%0d want %b%b%b %h ok=%b fc=%0d", f,
                 VSYNC_o, HSYNC_o, DE_o, VD_o, sync_ok_o, frame_cnt_o, e_vs, e_hs, e_de, e_vd, m_running, 8'(m_frames));
      end
      if (f == 255) begin
        n_checks++; if (frame_cnt_o !== 8'd255) begin n_fail++; $display("FAIL wrap_255: got %0d want 255", frame_cnt_o); end
      end
    end
    n_checks++; if (frame_cnt_o !== 8'd0) begin n_fail++; $display("FAIL wrap_0: got %0d want 0", frame_cnt_o); end
  endtask

  task automatic test_async_reset();
    drive(1'b0, 1'b1, 1'b1, 24'h5A5A5A);
    drive(1'b0, 1'b1, 1'b1, 24'h5A5A5A);
    drive(1'b0, 1'b0, 1'b1, 24'h5A5A5A);
    n_checks++; if (DE_o !== 1'b1) begin n_fail++; $display("FAIL pre_reset_de: got %b want 1", DE_o); end
    #2 VRST_Tx = 1'b1;
    #1;
    n_checks++; if (VSYNC_o !== 1'b0) begin n_fail++; $display("FAIL arst_vsync: got %b want 0", VSYNC_o); end
    n_checks++; if (HSYNC_o !== 1'b0) begin n_fail++; $display("FAIL arst_hsync: got %b want 0", HSYNC_o); end
    n_checks++; if (DE_o !== 1'b0) begin n_fail++; $display("FAIL arst_de: got %b want 0", DE_o); end
    n_checks++; if (VD_o !== '0) begin n_fail++; $display("FAIL arst_vd: got %h want 0", VD_o); end
    n_checks++; if (sync_ok_o !== 1'b0) begin n_fail++; $display("FAIL arst_sync_ok: got %b want 0", sync_ok_o); end
    n_checks++; if (frame_cnt_o !== 8'd0) begin n_fail++; $display("FAIL arst_frame_cnt: got %0d want 0", frame_cnt_o); end
    model_reset();
    @(posedge VCLK_Tx); #1;
    VRST_Tx = 1'b0;
    for (int c = 0; c < 300; c++) begin
      drive((c % 100) < 3, (c % 100) < 10, 1'b1, rnd_vd());
      n_checks++;
      if ({VSYNC_o, HSYNC_o, DE_o, VD_o, sync_ok_o, frame_cnt_o} !== {e_vs, e_hs, e_de, e_vd, m_running, 8'(m_frames)}) begin
        n_fail++;
        $display("FAIL relock_cycle c%0d: got %b%b%b %h ok=%b fc=%0d want %b%b%b %h ok=%b fc=%0d", c,
                 VSYNC_o, HSYNC_o, DE_o, VD_o, sync_ok_o, frame_cnt_o, e_vs, e_hs, e_de, e_vd, m_running, 8'(m_frames));
      end
    end
    n_checks++; if (sync_ok_o !== 1'b0) begin n_fail++; $display("FAIL relock_from_idle: got %b want 0", sync_ok_o); end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_random();
    test_polarity();
    test_blank();
    test_timeout();
    test_timeout_vs();
    test_frame_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
